conv_window_ctrl: RTL and testbench

- Sequencer for the 3x3 sliding-window register array of the first-layer convolution. The array is a chain of 8-bit enable registers feeding a 72-bit window register.
- Accepts a raster-order pixel stream, generates the shared shift enable for the window/line-buffer registers, and tracks row/column position.
- Flags when the 72-bit window holds a valid convolution position and stalls the stream under downstream backpressure.

---
 rtl/conv_window_ctrl.sv | 108 ++++++++++
 tb/tb_conv_window_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/conv_window_ctrl.sv
// conv_window_ctrl: 3x3 sliding-window sequencer (shift enable, position, window valid, backpressure).
// Optional abort input is enabled by defining CONV_CTRL_ABORT_EN.
module conv_window_ctrl #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int K     = 3,
    parameter int CW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic          pix_valid_i,
    output logic          pix_ready_o,
    input  logic          out_ready_i,
    output logic          shift_en_o,
    output logic          win_valid_o,
    output logic [CW-1:0] col_o,
    output logic [CW-1:0] row_o,
    output logic          busy_o,
`ifdef CONV_CTRL_ABORT_EN
    input  logic          abort_i,
`endif
    output logic          frame_done_o
);
    typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] ncol_q, ncol_d, nrow_q, nrow_d, col_q, col_d, row_q, row_d;
    logic          win_q, win_d;
    logic          abort, accept, last_pix, qual_pix, col_wrap, drain_exit;

`ifdef CONV_CTRL_ABORT_EN
    assign abort = abort_i && (state_q != IDLE);
`else
    assign abort = 1'b0;
`endif

    assign pix_ready_o = (state_q == FILL || state_q == RUN) && (!win_q || out_ready_i) && !abort;
    assign accept      = pix_valid_i && pix_ready_o;
    assign col_wrap    = ncol_q == CW'(IMG_W - 1);
    assign last_pix    = col_wrap && nrow_q == CW'(IMG_H - 1);
    assign qual_pix    = ncol_q >= CW'(K - 1) && nrow_q >= CW'(K - 1);
    assign drain_exit  = (state_q == DRAIN) && (!win_q || out_ready_i) && !abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  state_d = start_i ? FILL : IDLE;
            FILL:  state_d = (accept && qual_pix) ? (last_pix ? DRAIN : RUN) : FILL;
            RUN:   state_d = (accept && last_pix) ? DRAIN : RUN;
            DRAIN: state_d = drain_exit ? IDLE : DRAIN;
            default: state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    always_comb begin
        shift_en_o   = accept;
        win_valid_o  = win_q;
        col_o        = col_q;
        row_o        = row_q;
        busy_o       = state_q != IDLE;
        frame_done_o = drain_exit;
    end

    // Next-pixel position counters and the window-valid flag.
    always_comb begin
        ncol_d = ncol_q;
        nrow_d = nrow_q;
        col_d  = col_q;
        row_d  = row_q;
        win_d  = win_q && !out_ready_i;
        if ((state_q == IDLE && start_i) || abort) begin
            ncol_d = '0;
            nrow_d = '0;
            col_d  = '0;
            row_d  = '0;
            win_d  = 1'b0;
        end else if (accept) begin
            ncol_d = col_wrap ? '0 : ncol_q + CW'(1);
            nrow_d = col_wrap ? nrow_q + CW'(1) : nrow_q;
            col_d  = ncol_q;
            row_d  = nrow_q;
            win_d  = qual_pix || (win_q && !out_ready_i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ncol_q <= '0;
            nrow_q <= '0;
            col_q  <= '0;
            row_q  <= '0;
            win_q  <= 1'b0;
        end else begin
            ncol_q <= ncol_d;
            nrow_q <= nrow_d;
            col_q  <= col_d;
            row_q  <= row_d;
            win_q  <= win_d;
        end
    end
endmodule

// File: tb/tb_conv_window_ctrl.sv
// tb_conv_window_ctrl: table-driven and randomized check of conv_window_ctrl against a pixel-index model.
module tb_conv_window_ctrl;
    localparam int W = 4, H = 4, K = 3, CW = 8, N = W * H;
    localparam int BW = 28, BH = 28;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic start = 0, pv = 0, ordy = 0, abort = 0;
    logic pr, se, wv, busy, fd;
    logic [CW-1:0] col, row;

    logic b_start = 0, b_pv = 0, b_ordy = 0;
    logic b_pr, b_se, b_wv, b_busy, b_fd;
    logic [CW-1:0] b_col, b_row;

    conv_window_ctrl #(.IMG_W(W), .IMG_H(H), .K(K), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .pix_valid_i(pv), .pix_ready_o(pr),
        .out_ready_i(ordy), .shift_en_o(se), .win_valid_o(wv), .col_o(col), .row_o(row),
        .busy_o(busy),
`ifdef CONV_CTRL_ABORT_EN
        .abort_i(abort),
`endif
        .frame_done_o(fd));

    conv_window_ctrl #(.IMG_W(BW), .IMG_H(BH), .K(K), .CW(CW)) dut_b (
        .clk(clk), .rst_n(rst_n), .start_i(b_start), .pix_valid_i(b_pv), .pix_ready_o(b_pr),
        .out_ready_i(b_ordy), .shift_en_o(b_se), .win_valid_o(b_wv), .col_o(b_col), .row_o(b_row),
        .busy_o(b_busy),
`ifdef CONV_CTRL_ABORT_EN
        .abort_i(abort),
`endif
        .frame_done_o(b_fd));

    int errors = 0, checks = 0;
    bit m_act, m_win;
    int m_idx, m_col, m_row;
    int n_shift, n_win, n_done;
    int pos_q[$];
    int exp_pos[4] = '{10, 11, 14, 15};

    typedef struct {
        int vmode;      // 0 always, 1 toggle, 2 random
        int omode;      // 0 always, 1 stall 5 cycles at first window, 2 random
        bit start_mid;  // extra start pulse while busy
        int exp_shift;
        int exp_win;
        int exp_done;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_act = 0; m_win = 0; m_idx = 0; m_col = 0; m_row = 0;
    endtask

    // One clock cycle: drive inputs, compare against the model, advance the model.
    task automatic step(input bit s, input bit v, input bit o);
        bit was, e_ready, e_acc, e_done;
        logic [20:0] got, exp;
        start = s; pv = v; ordy = o;
        #1;
        was     = m_act;
        e_ready = m_act && m_idx < N && (!m_win || o);
        e_acc   = v && e_ready;
        e_done  = m_act && m_idx == N && (!m_win || o);
        exp = {e_ready, e_acc, m_win, m_act, e_done, 8'(m_col), 8'(m_row)};
        got = {pr, se, wv, busy, fd, col, row};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL cycle_outputs idx=%0d: got %h expected %h", m_idx, got, exp);
        end
        if (se) n_shift++;
        if (wv && o) begin n_win++; pos_q.push_back(int'(row) * W + int'(col)); end
        if (fd) n_done++;
        if (e_acc) begin
            m_col = m_idx % W;
            m_row = m_idx / W;
            m_win = (m_row >= K - 1 && m_col >= K - 1) || (m_win && !o);
            m_idx++;
        end else m_win = m_win && !o;
        if (e_done) m_act = 0;
        if (s && !was) begin m_act = 1; m_idx = 0; m_col = 0; m_row = 0; m_win = 0; end
        @(negedge clk);
    endtask

    task automatic run_frame(input vec_t vc);
        int c, first;
        bit v, o;
        n_shift = 0; n_win = 0; n_done = 0; pos_q.delete();
        first = -1;
        step(1, 1, 1);
        c = 0;
        while (m_act && c < 400) begin
            v = vc.vmode == 0 ? 1'b1 : vc.vmode == 1 ? c[0] == 1'b0 : 1'($urandom_range(0, 1));
            if (wv && first < 0) first = c;
            o = vc.omode == 0 ? 1'b1 : vc.omode == 1 ? !(first >= 0 && c < first + 5)
                : ($urandom_range(0, 3) != 0);
            step(vc.start_mid && c == 5, v, o);
            c++;
        end
        chk("frame_timeout", int'(c < 400), 1);
        chk("shift_count", n_shift, vc.exp_shift);
        chk("win_count", n_win, vc.exp_win);
        chk("done_count", n_done, vc.exp_done);
        for (int i = 0; i < 4; i++) chk("win_pos", i < pos_q.size() ? pos_q[i] : -1, exp_pos[i]);
        step(0, 0, 1);
    endtask

    initial begin
        int bw, bd, bmr, bmc, c;
        vecs[0] = '{0, 0, 0, 16, 4, 1};
        vecs[1] = '{0, 1, 0, 16, 4, 1};
        vecs[2] = '{1, 0, 0, 16, 4, 1};
        vecs[3] = '{0, 0, 1, 16, 4, 1};
        vecs[4] = '{2, 2, 0, 16, 4, 1};
        vecs[5] = '{2, 2, 1, 16, 4, 1};
        model_reset();
        @(negedge clk);
        step(0, 1, 1);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(0, 1, 1);
        for (int i = 0; i < 6; i++) run_frame(vecs[i]);
        for (int i = 0; i < 10; i++) run_frame('{2, 2, 0, 16, 4, 1});

        // Asynchronous reset mid-frame after 7 accepted pixels.
        n_shift = 0; n_done = 0;
        step(1, 1, 1);
        c = 0;
        while (n_shift < 7 && c < 50) begin step(0, 1, 1); c++; end
        chk("pre_reset_shifts", n_shift, 7);
        rst_n = 1'b0;
        #1;
        chk("reset_outputs", int'({pr, se, wv, busy, fd, col, row}), 0);
        model_reset();
        step(0, 1, 1);
        rst_n = 1'b1;
        step(0, 1, 1);
        chk("reset_no_done", n_done, 0);
        run_frame(vecs[0]);

        // Large image frame on the second instance.
        bw = 0; bd = 0; bmr = 0; bmc = 0;
        b_start = 1; b_pv = 1; b_ordy = 1;
        @(negedge clk);
        b_start = 0;
        c = 0;
        while ((b_busy || c == 0) && c < 2000) begin
            #1;
            if (b_wv) bw++;
            if (b_fd) bd++;
            if (int'(b_row) > bmr) bmr = int'(b_row);
            if (int'(b_col) > bmc) bmc = int'(b_col);
            @(negedge clk);
            c++;
        end
        #1;
        chk("big_timeout", int'(c < 2000), 1);
        chk("big_windows", bw, (BW - K + 1) * (BH - K + 1));
        chk("big_done", bd, 1);
        chk("big_max_row", bmr, BH - 1);
        chk("big_max_col", bmc, BW - 1);
        chk("big_idle", int'(b_busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
